// File: rtl/trap_pkg.sv
// Shared trap definitions: cause encodings, controller FSM states and the
// architectural PC width. The trap detector imports the same cause constants.
package trap_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] CAUSE_NONE         = 3'd0;
    localparam logic [2:0] CAUSE_LSU_FAULT    = 3'd1;
    localparam logic [2:0] CAUSE_ILLEGAL      = 3'd2;
    localparam logic [2:0] CAUSE_IFETCH_FAULT = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_HANDLER  = 3'd3,
        ST_RETURN   = 3'd4
    } trap_state_e;

    // Only the three defined causes start a trap; reserved codes 4..7 act as none.
    function automatic logic is_trap(input logic [2:0] cause);
        return (cause == CAUSE_LSU_FAULT) ||
               (cause == CAUSE_ILLEGAL)   ||
               (cause == CAUSE_IFETCH_FAULT);
    endfunction

endpackage

// File: rtl/trap_handler_ctrl_if.sv
// Bundle between the trap detector / fetch stage and the trap-response
// controller. The master side (pipeline) drives trap requests and mret; the
// slave side (controller) drives flush, redirect and the architectural copies.
interface trap_handler_ctrl_if #(
    parameter int XLEN = trap_pkg::XLEN
);
    logic [2:0]      trap_type;
    logic [XLEN-1:0] trap_mepc;
    logic [XLEN-1:0] trap_vector;
    logic            mret;

    logic            flush;
    logic            stall_if;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_target;
    logic            trap_taken;
    logic            in_handler;
    logic [2:0]      mcause_q;
    logic [XLEN-1:0] mepc_q;
    logic            nested_trap;

    modport master (
        output trap_type, trap_mepc, trap_vector, mret,
        input  flush, stall_if, pc_redirect, pc_target, trap_taken,
               in_handler, mcause_q, mepc_q, nested_trap
    );

    modport slave (
        input  trap_type, trap_mepc, trap_vector, mret,
        output flush, stall_if, pc_redirect, pc_target, trap_taken,
               in_handler, mcause_q, mepc_q, nested_trap
    );
endinterface

// File: rtl/trap_handler_ctrl.sv
// Trap-response controller: accepts a trap, drains the pipeline for a fixed
// number of cycles, redirects fetch to the handler, tracks handler residency
// and redirects back to the saved PC on mret. All outputs are Moore.
module trap_handler_ctrl #(
    parameter int XLEN         = trap_pkg::XLEN,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rstn,
    trap_handler_ctrl_if.slave bus
);
    import trap_pkg::*;

    // Counter preload: the FLUSH state lasts cnt_init+1 cycles.
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    trap_state_e     state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic [2:0]      mcause_reg;
    logic [XLEN-1:0] mepc_reg;
    logic [XLEN-1:0] vec_reg;
    logic            nested_reg;

    logic            capture;
    logic            nested_set;

    logic            flush_out;
    logic            stall_out;
    logic            redirect_out;
    logic [XLEN-1:0] target_out;
    logic            taken_out;
    logic            handler_out;

    // State, counter and nested-trap flag; reset aborts any trap in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 4'd0;
            nested_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            if (nested_set) begin
                nested_reg <= 1'b1;
            end
        end
    end

    // Architectural cause/return PC and handler vector, captured only on accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcause_reg <= CAUSE_NONE;
            mepc_reg   <= '0;
            vec_reg    <= '0;
        end else if (capture) begin
            mcause_reg <= bus.trap_type;
            mepc_reg   <= bus.trap_mepc;
            vec_reg    <= bus.trap_vector;
        end
    end

    // Next-state logic; trap/mret are only looked at in IDLE and HANDLER since
    // in the other states they belong to instructions being squashed.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        nested_set = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (is_trap(bus.trap_type)) begin
                    capture    = 1'b1;
                    cnt_next   = CNT_INIT;
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_REDIRECT;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_REDIRECT: begin
                state_next = ST_HANDLER;
            end
            ST_HANDLER: begin
                // A trap inside the handler is only flagged; it also swallows
                // a simultaneous mret.
                if (is_trap(bus.trap_type)) begin
                    nested_set = 1'b1;
                end else if (bus.mret) begin
                    state_next = ST_RETURN;
                end
            end
            ST_RETURN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state only.
    always_comb begin
        flush_out    = 1'b0;
        stall_out    = 1'b0;
        redirect_out = 1'b0;
        target_out   = '0;
        taken_out    = 1'b0;
        handler_out  = 1'b0;
        unique case (state_reg)
            ST_FLUSH: begin
                flush_out = 1'b1;
                stall_out = 1'b1;
                // The counter is at its preload value only in the first cycle.
                taken_out = (cnt_reg == CNT_INIT);
            end
            ST_REDIRECT: begin
                flush_out    = 1'b1;
                redirect_out = 1'b1;
                target_out   = vec_reg;
            end
            ST_HANDLER: begin
                handler_out = 1'b1;
            end
            ST_RETURN: begin
                flush_out    = 1'b1;
                redirect_out = 1'b1;
                target_out   = mepc_reg;
                handler_out  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.flush       = flush_out;
    assign bus.stall_if    = stall_out;
    assign bus.pc_redirect = redirect_out;
    assign bus.pc_target   = target_out;
    assign bus.trap_taken  = taken_out;
    assign bus.in_handler  = handler_out;
    assign bus.mcause_q    = mcause_reg;
    assign bus.mepc_q      = mepc_reg;
    assign bus.nested_trap = nested_reg;

endmodule

// File: tb/tb_trap_handler_ctrl.sv
// Directed bench for trap_handler_ctrl with FLUSH_CYCLES=3.
module tb_trap_handler_ctrl;

    localparam int XLEN = 64;

    logic clk;
    logic rstn;
    int   tests_run;
    int   tests_failed;
    int   taken_count;

    trap_handler_ctrl_if #(.XLEN(XLEN)) bus_if ();

    trap_handler_ctrl #(
        .XLEN        (XLEN),
        .FLUSH_CYCLES(3)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        taken_count += int'(bus_if.trap_taken);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".flush"}, 64'(bus_if.flush), 64'd0);
        chk({tag, ".redir"}, 64'(bus_if.pc_redirect), 64'd0);
        chk({tag, ".target"}, bus_if.pc_target, 64'd0);
        chk({tag, ".taken"}, 64'(bus_if.trap_taken), 64'd0);
        chk({tag, ".inh"}, 64'(bus_if.in_handler), 64'd0);
        chk({tag, ".stall"}, 64'(bus_if.stall_if), 64'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        taken_count  = 0;
        rstn               = 1'b0;
        bus_if.trap_type   = 3'd0;
        bus_if.trap_mepc   = '0;
        bus_if.trap_vector = '0;
        bus_if.mret        = 1'b0;

        // Reset state
        tick();
        tick();
        chk_quiet("rst");
        chk("rst.mcause", 64'(bus_if.mcause_q), 64'd0);
        chk("rst.mepc", bus_if.mepc_q, 64'd0);
        chk("rst.nested", 64'(bus_if.nested_trap), 64'd0);
        rstn = 1'b1;
        tick();

        // Illegal-instruction trap accepted at edge 0
        bus_if.trap_type   = 3'd2;
        bus_if.trap_mepc   = 64'h104;
        bus_if.trap_vector = 64'd480;
        taken_count = 0;
        tick();                                     // cycle 1
        bus_if.trap_type = 3'd0;
        chk("t1.c1.flush", 64'(bus_if.flush), 64'd1);
        chk("t1.c1.taken", 64'(bus_if.trap_taken), 64'd1);
        chk("t1.c1.stall", 64'(bus_if.stall_if), 64'd1);
        chk("t1.c1.redir", 64'(bus_if.pc_redirect), 64'd0);
        tick();                                     // cycle 2
        chk("t1.c2.flush", 64'(bus_if.flush), 64'd1);
        chk("t1.c2.taken", 64'(bus_if.trap_taken), 64'd0);
        tick();                                     // cycle 3
        chk("t1.c3.flush", 64'(bus_if.flush), 64'd1);
        chk("t1.c3.redir", 64'(bus_if.pc_redirect), 64'd0);
        tick();                                     // cycle 4: REDIRECT
        chk("t1.c4.redir", 64'(bus_if.pc_redirect), 64'd1);
        chk("t1.c4.target", bus_if.pc_target, 64'd480);
        chk("t1.c4.flush", 64'(bus_if.flush), 64'd1);
        chk("t1.c4.stall", 64'(bus_if.stall_if), 64'd0);
        chk("t1.c4.inh", 64'(bus_if.in_handler), 64'd0);
        tick();                                     // cycle 5: HANDLER
        chk("t1.c5.inh", 64'(bus_if.in_handler), 64'd1);
        chk("t1.c5.flush", 64'(bus_if.flush), 64'd0);
        chk("t1.c5.target", bus_if.pc_target, 64'd0);
        chk("t1.mcause", 64'(bus_if.mcause_q), 64'd2);
        chk("t1.mepc", bus_if.mepc_q, 64'h104);
        chk("t1.taken_cnt", 64'(taken_count), 64'd1);
        for (int i = 6; i <= 10; i++) tick();       // cycles 6..10
        chk("t1.c10.inh", 64'(bus_if.in_handler), 64'd1);

        // mret at edge 10
        bus_if.mret = 1'b1;
        tick();                                     // cycle 11: RETURN
        bus_if.mret = 1'b0;
        chk("t2.c11.redir", 64'(bus_if.pc_redirect), 64'd1);
        chk("t2.c11.target", bus_if.pc_target, 64'h104);
        chk("t2.c11.flush", 64'(bus_if.flush), 64'd1);
        chk("t2.c11.inh", 64'(bus_if.in_handler), 64'd1);
        tick();                                     // cycle 12: IDLE
        chk_quiet("t2.c12");
        chk("t2.mepc", bus_if.mepc_q, 64'h104);
        chk("t2.mcause", 64'(bus_if.mcause_q), 64'd2);

        // Enter handler again, then trap + mret in the same cycle
        bus_if.trap_type   = 3'd2;
        bus_if.trap_mepc   = 64'h200;
        bus_if.trap_vector = 64'h300;
        tick();
        bus_if.trap_type = 3'd0;
        for (int i = 0; i < 4; i++) tick();
        chk("t3.inh", 64'(bus_if.in_handler), 64'd1);
        chk("t3.nested0", 64'(bus_if.nested_trap), 64'd0);
        bus_if.trap_type   = 3'd1;
        bus_if.trap_mepc   = 64'hDEAD;
        bus_if.trap_vector = 64'hBEEF;
        bus_if.mret        = 1'b1;
        tick();
        bus_if.trap_type = 3'd0;
        bus_if.mret      = 1'b0;
        chk("t3.nested", 64'(bus_if.nested_trap), 64'd1);
        chk("t3.inh2", 64'(bus_if.in_handler), 64'd1);
        chk("t3.redir", 64'(bus_if.pc_redirect), 64'd0);
        chk("t3.mcause", 64'(bus_if.mcause_q), 64'd2);
        chk("t3.mepc", bus_if.mepc_q, 64'h200);
        tick();
        chk("t3.inh3", 64'(bus_if.in_handler), 64'd1);
        chk("t3.nested2", 64'(bus_if.nested_trap), 64'd1);
        bus_if.mret = 1'b1;
        tick();
        bus_if.mret = 1'b0;
        chk("t3.ret.target", bus_if.pc_target, 64'h200);
        tick();
        chk("t3.idle.inh", 64'(bus_if.in_handler), 64'd0);
        chk("t3.nested3", 64'(bus_if.nested_trap), 64'd1);

        // Type-1 trap, then type 3 held through FLUSH and REDIRECT
        bus_if.trap_type   = 3'd1;
        bus_if.trap_mepc   = 64'h400;
        bus_if.trap_vector = 64'h500;
        taken_count = 0;
        tick();                                     // FLUSH 1
        chk("t4.c1.taken", 64'(bus_if.trap_taken), 64'd1);
        bus_if.trap_type   = 3'd3;
        bus_if.trap_mepc   = 64'h999;
        bus_if.trap_vector = 64'h888;
        tick();                                     // FLUSH 2
        tick();                                     // FLUSH 3
        tick();                                     // REDIRECT
        chk("t4.target", bus_if.pc_target, 64'h500);
        tick();                                     // HANDLER
        bus_if.trap_type = 3'd0;
        chk("t4.inh", 64'(bus_if.in_handler), 64'd1);
        chk("t4.mcause", 64'(bus_if.mcause_q), 64'd1);
        chk("t4.mepc", bus_if.mepc_q, 64'h400);
        chk("t4.taken_cnt", 64'(taken_count), 64'd1);
        bus_if.mret = 1'b1;
        tick();
        bus_if.mret = 1'b0;
        tick();

        // mret and reserved cause in IDLE do nothing
        bus_if.mret = 1'b1;
        tick();
        bus_if.mret = 1'b0;
        chk_quiet("t5.mret");
        bus_if.trap_type = 3'd5;
        tick();
        chk_quiet("t5.rsv1");
        tick();
        bus_if.trap_type = 3'd0;
        chk_quiet("t5.rsv2");
        chk("t5.mcause", 64'(bus_if.mcause_q), 64'd1);

        // Asynchronous reset in FLUSH cycle 2
        bus_if.trap_type   = 3'd2;
        bus_if.trap_mepc   = 64'h600;
        bus_if.trap_vector = 64'h610;
        tick();
        bus_if.trap_type = 3'd0;
        tick();
        chk("t6.flush_pre", 64'(bus_if.flush), 64'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk_quiet("t6.async");
        chk("t6.mcause", 64'(bus_if.mcause_q), 64'd0);
        chk("t6.mepc", bus_if.mepc_q, 64'd0);
        chk("t6.nested", 64'(bus_if.nested_trap), 64'd0);
        tick();
        rstn = 1'b1;
        bus_if.trap_type   = 3'd1;
        bus_if.trap_mepc   = 64'h700;
        bus_if.trap_vector = 64'h800;
        tick();
        bus_if.trap_type = 3'd0;
        chk("t6.taken", 64'(bus_if.trap_taken), 64'd1);
        tick();
        tick();
        tick();
        chk("t6.target", bus_if.pc_target, 64'h800);
        tick();
        chk("t6.inh", 64'(bus_if.in_handler), 64'd1);
        chk("t6.mcause1", 64'(bus_if.mcause_q), 64'd1);

        // Trap during RETURN ignored, same level accepted once back in IDLE
        bus_if.mret = 1'b1;
        tick();                                     // RETURN
        bus_if.mret        = 1'b0;
        bus_if.trap_type   = 3'd3;
        bus_if.trap_mepc   = 64'h900;
        bus_if.trap_vector = 64'h910;
        chk("t7.ret.target", bus_if.pc_target, 64'h700);
        tick();                                     // IDLE
        chk_quiet("t7.idle");
        tick();                                     // FLUSH 1
        bus_if.trap_type = 3'd0;
        chk("t7.taken", 64'(bus_if.trap_taken), 64'd1);
        chk("t7.mcause", 64'(bus_if.mcause_q), 64'd3);
        chk("t7.mepc", bus_if.mepc_q, 64'h900);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/trap_handler_ctrl.md
# trap_handler_ctrl

Trap-response controller for the RV64I pipeline. It consumes the trap cause, saved return PC and vector address from the trap detector, drains the pipeline, redirects fetch to the handler, and tracks handler residency. On `mret` it redirects fetch back to the saved PC. It holds the architectural mcause/mepc copies used by the rest of the core.

## Interface
Parameters:
- `XLEN`, 64, PC/address width
- `FLUSH_CYCLES`, 3, number of drain cycles before redirect; legal range 1..15

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `trap_type`  in  3  trap cause: 0 none, 1 load/store access fault, 2 illegal instruction, 3 instruction access fault; 4..7 reserved, treated as 0
- `trap_mepc`  in  XLEN  return PC associated with the current trap
- `trap_vector`  in  XLEN  handler entry address for the current trap
- `mret`  in  1  an mret instruction is retiring this cycle
- `flush`  out  1  squash all in-flight IF/ID/EX/MEM instructions
- `stall_if`  out  1  hold fetch PC
- `pc_redirect`  out  1  load `pc_target` into the fetch PC this cycle
- `pc_target`  out  XLEN  redirect address
- `trap_taken`  out  1  one-cycle pulse when a trap is accepted
- `in_handler`  out  1  trap handler executing
- `mcause_q`  out  3  latched cause
- `mepc_q`  out  XLEN  latched return PC
- `nested_trap`  out  1  sticky: a trap arrived while in HANDLER

## Operation
- FSM states: IDLE, FLUSH, REDIRECT, HANDLER, RETURN. All outputs are decoded from registered state and registers (Moore), with no combinational input-to-output paths.
- IDLE: a `trap_type` in 1..3 captures `mcause_q`<=trap_type, `mepc_q`<=trap_mepc, `vec_q`<=trap_vector, and loads cnt<=FLUSH_CYCLES-1. The FSM then goes to FLUSH. `mret` in IDLE is ignored.
- FLUSH: `flush`=1, `stall_if`=1, `trap_taken`=1 only in the first FLUSH cycle. cnt decrements each cycle; when cnt==0 the FSM goes to REDIRECT.
- REDIRECT: `pc_redirect`=1, `pc_target`=vec_q, `flush`=1. The FSM always goes to HANDLER next cycle.
- HANDLER: `in_handler`=1.
  - A trap (1..3) sets `nested_trap`. The trap is not captured, and the FSM stays in HANDLER.
  - Otherwise `mret` moves the FSM to RETURN.
  - If a trap and `mret` occur in the same cycle, the trap wins: `nested_trap` is set and `mret` is dropped.
- RETURN: `pc_redirect`=1, `pc_target`=mepc_q, `flush`=1, `in_handler`=1. The FSM goes to IDLE next cycle.
- `trap_type` and `mret` are ignored in FLUSH, REDIRECT and RETURN. They come from squashed instructions.
- A level `trap_type` still asserted when the FSM re-enters IDLE is a new trap and is accepted.
- `pc_target` is 0 whenever `pc_redirect`=0.
- `mcause_q` and `mepc_q` hold their values until the next accepted trap. They are not cleared on return.
- `nested_trap` clears only on reset.
- cnt width is 4 bits. FLUSH_CYCLES=1 gives exactly one FLUSH cycle.

## Timing
- Reset: state IDLE, cnt 0. Every output is 0, including `mcause_q`, `mepc_q`, `vec_q` and `nested_trap`. Assertion mid-operation aborts immediately to IDLE.
- Trap sampled at edge N (IDLE):
  - `trap_taken` and `flush` are high in cycle N+1.
  - FLUSH occupies cycles N+1..N+FLUSH_CYCLES.
  - REDIRECT is at N+FLUSH_CYCLES+1.
  - `in_handler` rises at N+FLUSH_CYCLES+2.
- `mret` sampled at edge M (HANDLER): RETURN redirect is in cycle M+1, and IDLE is at M+2. The earliest new trap is accepted at edge M+2.
- Trap-to-handler-fetch latency is FLUSH_CYCLES+1 cycles.

## Structure
- Shared package `trap_pkg` holds:
  - cause constants `CAUSE_NONE`=0, `CAUSE_LSU_FAULT`=1, `CAUSE_ILLEGAL`=2, `CAUSE_IFETCH_FAULT`=3
  - the FSM state enum
  - `XLEN`
- The trap detector also imports these cause constants.
- Single module; no sub-module is warranted.

## Test plan
- FLUSH_CYCLES=3. trap_type=2, trap_mepc=0x104, trap_vector=480 at edge 0 → `flush` high in cycles 1–3, `trap_taken` in cycle 1 only, `pc_redirect`=1 with `pc_target`=480 in cycle 4, `in_handler`=1 from cycle 5, `mcause_q`=2, `mepc_q`=0x104.
- From HANDLER, `mret` at edge 10 → cycle 11 `pc_redirect`=1, `pc_target`=0x104, `flush`=1; cycle 12 IDLE with `in_handler`=0. `mepc_q` is still 0x104.
- In HANDLER, trap_type=1 and `mret` in the same cycle → `nested_trap`=1 and stays 1, no redirect, `mcause_q` unchanged at 2, state stays HANDLER.
- trap_type=3 held during FLUSH and REDIRECT after a type-1 trap → ignored. `mcause_q`=1, exactly one `trap_taken` pulse.
- `mret` in IDLE, and trap_type=5 in IDLE → no output activity.
- `rstn` low during FLUSH cycle 2 → all outputs 0 asynchronously. After release, IDLE accepts trap_type=1 normally.
